fetch_prefetch_queue: RTL and testbench

Parametrised instruction fetch stage with an in-order prefetch buffer. Issues sequential instruction reads to instruction memory over a request/response interface, buffers returned words with their PCs, and hands them to decode over a valid/ready handshake. A jump flushes the buffer, redirects fetch, and discards every response still in flight.

---
 rtl/fetch_prefetch_queue.sv | 148 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction fetch stage with an in-order prefetch buffer. It issues
// sequential reads to instruction memory. Returned words are buffered together
// with their PCs and handed to decode over a valid/ready handshake. A jump
// flushes the buffer, redirects fetch, and discards every response still in
// flight.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   i_en_jmp            redirect fetch this cycle
//   i_jmp_address       redirect target, used verbatim
//   o_mem_req           read request valid
//   i_mem_ready         memory accepts the request
//   o_mem_addr          request address
//   i_mem_rvalid        read data valid; responses return in request order
//   i_mem_rdata         read data
//   o_valid             buffer head valid
//   i_ready             decode accepts the head
//   o_instruction       head instruction, 0 when the buffer is empty
//   o_process_counter   PC of the head instruction, 0 when the buffer is empty
module fetch_prefetch_queue #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en_jmp,
  input  logic [ADDR_WIDTH-1:0] i_jmp_address,
  output logic                  o_mem_req,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rvalid,
  input  logic [INST_WIDTH-1:0] i_mem_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0] o_process_counter
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);
  localparam logic [CNT_W:0]        DEPTH_X = (CNT_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;

  logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_q [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           head_valid;
  logic           issue;
  logic           push;
  logic           pop;

  // Buffered words plus in-flight requests never exceed DEPTH, so every
  // response is guaranteed a free slot when it arrives.
  assign occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign head_valid = (count_q != '0);

  assign o_mem_req  = !rst && !i_en_jmp && (occupancy < DEPTH_X);
  assign o_mem_addr = fetch_pc_q;

  assign issue = o_mem_req && i_mem_ready;
  // Responses owed to a pre-jump request stream are dropped, never pushed.
  assign push  = i_mem_rvalid && !i_en_jmp && (discard_q == '0);
  assign pop   = head_valid && i_ready && !i_en_jmp;

  assign o_valid           = head_valid;
  assign o_instruction     = head_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign o_process_counter = head_valid ? fifo_pc_q[rd_ptr_q]   : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(i_mem_rvalid);

    if (issue) begin
      fetch_pc_d = fetch_pc_q + STEP;
    end

    if (i_en_jmp) begin
      // Every request still outstanding after this cycle belongs to the old
      // stream; a response landing in the jump cycle itself is dropped here.
      fetch_pc_d = i_jmp_address;
      resp_pc_d  = i_jmp_address;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_q - CNT_W'(i_mem_rvalid);
    end else begin
      if (i_mem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + STEP;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_inst_q[wr_ptr_q] <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue with default parameters
// (16-bit PC, 32-bit words, DEPTH 4, RESET_PC 0, PC_STEP 4). A small
// in-order memory model with selectable latency answers each request with
// the word {~addr, addr}.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        i_en_jmp;
  logic [15:0] i_jmp_address;
  logic        o_mem_req;
  logic        i_mem_ready;
  logic [15:0] o_mem_addr;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [15:0] o_process_counter;

  int checks;
  int errors;
  int issued_count;
  int mem_latency;

  logic        pipe_v [4];
  logic [15:0] pipe_a [4];

  fetch_prefetch_queue dut (
    .clk               (clk),
    .rst               (rst),
    .i_en_jmp          (i_en_jmp),
    .i_jmp_address     (i_jmp_address),
    .o_mem_req         (o_mem_req),
    .i_mem_ready       (i_mem_ready),
    .o_mem_addr        (o_mem_addr),
    .i_mem_rvalid      (i_mem_rvalid),
    .i_mem_rdata       (i_mem_rdata),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_instruction     (o_instruction),
    .o_process_counter (o_process_counter)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Empty the memory model's response pipeline.
  task automatic clear_mem();
    for (int i = 0; i < 4; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = 16'h0;
    end
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'h0;
  endtask

  // Ends the current cycle: records whether a request was accepted, crosses
  // the rising edge, then advances the memory model and drives this cycle's
  // response. Returns at posedge+2 with everything settled.
  task automatic tick();
    logic        issue_now;
    logic [15:0] issue_addr;
    #1;
    issue_now  = o_mem_req && i_mem_ready;
    issue_addr = o_mem_addr;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pipe_v[i] = pipe_v[i+1];
      pipe_a[i] = pipe_a[i+1];
    end
    pipe_v[3] = 1'b0;
    pipe_a[3] = 16'h0;
    if (issue_now) begin
      issued_count = issued_count + 1;
      pipe_v[mem_latency-1] = 1'b1;
      pipe_a[mem_latency-1] = issue_addr;
    end
    i_mem_rvalid = pipe_v[0];
    i_mem_rdata  = pipe_v[0] ? word_of(pipe_a[0]) : 32'h0;
    #1;
  endtask

  // Holds reset for two cycles with idle inputs and a clean memory, then
  // releases it; returns inside the first cycle after release.
  task automatic do_reset();
    rst           = 1'b1;
    i_en_jmp      = 1'b0;
    i_jmp_address = 16'h0;
    i_ready       = 1'b0;
    i_mem_ready   = 1'b1;
    mem_latency   = 1;
    clear_mem();
    tick();
    tick();
    issued_count = 0;
    rst = 1'b0;
    #1;
  endtask

  // Outputs while reset is held, then the first request after release.
  task automatic test_reset();
    rst           = 1'b1;
    i_en_jmp      = 1'b0;
    i_jmp_address = 16'h0;
    i_ready       = 1'b0;
    i_mem_ready   = 1'b1;
    mem_latency   = 1;
    issued_count  = 0;
    clear_mem();
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_instruction !== 32'h0 || o_process_counter !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_head: valid=%b inst=%h pc=%h, required 0/0/0",
               o_valid, o_instruction, o_process_counter);
    end
    checks++;
    if (o_mem_req !== 1'b0 || o_mem_addr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_req: req=%b addr=%h, required 0/0000", o_mem_req, o_mem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_first_req: req=%b addr=%h, required 1/0000", o_mem_req, o_mem_addr);
    end
  endtask

  // 1-cycle memory, decode always ready: one request and one instruction
  // per cycle, first instruction two cycles after the first request.
  task automatic test_stream();
    do_reset();
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 16'(4 * c)) begin
        errors++;
        $display("[TB] FAIL stream_req c=%0d: req=%b addr=%h, required 1/%h",
                 c, o_mem_req, o_mem_addr, 16'(4 * c));
      end
      checks++;
      if (c < 2) begin
        if (o_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stream_empty c=%0d: valid=%b, required 0", c, o_valid);
        end
      end else if (o_valid !== 1'b1 || o_process_counter !== 16'(4 * (c - 2)) ||
                   o_instruction !== word_of(16'(4 * (c - 2)))) begin
        errors++;
        $display("[TB] FAIL stream_head c=%0d: valid=%b pc=%h inst=%h, required 1/%h/%h",
                 c, o_valid, o_process_counter, o_instruction,
                 16'(4 * (c - 2)), word_of(16'(4 * (c - 2))));
      end
      tick();
    end
  endtask

  // Decode stalled: exactly DEPTH requests, then no more until entries drain.
  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c >= 4) begin
        checks++;
        if (o_mem_req !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_req_low c=%0d: req=%b, required 0", c, o_mem_req);
        end
      end
      tick();
    end
    checks++;
    if (issued_count !== 4) begin
      errors++;
      $display("[TB] FAIL bp_issued: issued=%0d, required 4", issued_count);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_process_counter !== 16'(4 * k) || o_instruction !== word_of(16'(4 * k))) begin
        errors++;
        $display("[TB] FAIL bp_pop k=%0d: valid=%b pc=%h inst=%h, required 1/%h/%h",
                 k, o_valid, o_process_counter, o_instruction, 16'(4 * k), word_of(16'(4 * k)));
      end
      if (k == 1) begin
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0010) begin
          errors++;
          $display("[TB] FAIL bp_resume: req=%b addr=%h, required 1/0010", o_mem_req, o_mem_addr);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0010) begin
      errors++;
      $display("[TB] FAIL bp_after: valid=%b pc=%h, required 1/0010", o_valid, o_process_counter);
    end
  endtask

  // 3-cycle memory, two requests in flight when the jump hits: both stale
  // responses are dropped and the first delivered word belongs to 0x0100.
  task automatic test_jump_discard();
    do_reset();
    mem_latency = 3;
    i_ready     = 1'b1;
    tick();
    tick();
    i_mem_ready   = 1'b0;
    i_en_jmp      = 1'b1;
    i_jmp_address = 16'h0100;
    #1;
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jd_req_in_jump: req=%b, required 0", o_mem_req);
    end
    tick();
    i_en_jmp    = 1'b0;
    i_mem_ready = 1'b1;
    #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL jd_redirect: req=%b addr=%h, required 1/0100", o_mem_req, o_mem_addr);
    end
    for (int c = 3; c < 7; c++) begin
      if (c > 3) #1;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL jd_stale c=%0d: valid=%b pc=%h, required valid 0", c, o_valid, o_process_counter);
      end
      tick();
    end
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0100 || o_instruction !== word_of(16'h0100)) begin
      errors++;
      $display("[TB] FAIL jd_target: valid=%b pc=%h inst=%h, required 1/0100/%h",
               o_valid, o_process_counter, o_instruction, word_of(16'h0100));
    end
  endtask

  // Jump coinciding with a response and a pop: response dropped, head
  // flushed, and the new stream is not starved by a stray discard.
  task automatic test_jump_same_cycle();
    do_reset();
    i_ready = 1'b1;
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL js_pre: valid=%b pc=%h, required 1/0004", o_valid, o_process_counter);
    end
    i_en_jmp      = 1'b1;
    i_jmp_address = 16'h0200;
    #1;
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL js_req_in_jump: req=%b, required 0", o_mem_req);
    end
    tick();
    i_en_jmp = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL js_after: valid=%b req=%b addr=%h, required 0/1/0200", o_valid, o_mem_req, o_mem_addr);
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL js_no_bypass: valid=%b, required 0", o_valid);
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0200 || o_instruction !== word_of(16'h0200)) begin
      errors++;
      $display("[TB] FAIL js_target: valid=%b pc=%h inst=%h, required 1/0200/%h",
               o_valid, o_process_counter, o_instruction, word_of(16'h0200));
    end
  endtask

  // PC wraps from 0xFFFC to 0x0000.
  task automatic test_wrap();
    do_reset();
    i_ready       = 1'b1;
    i_en_jmp      = 1'b1;
    i_jmp_address = 16'hFFFC;
    tick();
    i_en_jmp = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'hFFFC) begin
      errors++;
      $display("[TB] FAIL wrap_req0: req=%b addr=%h, required 1/fffc", o_mem_req, o_mem_addr);
    end
    tick();
    #1;
    checks++;
    if (o_mem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_req1: addr=%h, required 0000", o_mem_addr);
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'hFFFC || o_instruction !== word_of(16'hFFFC)) begin
      errors++;
      $display("[TB] FAIL wrap_head0: valid=%b pc=%h inst=%h, required 1/fffc/%h",
               o_valid, o_process_counter, o_instruction, word_of(16'hFFFC));
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0000 || o_instruction !== word_of(16'h0000)) begin
      errors++;
      $display("[TB] FAIL wrap_head1: valid=%b pc=%h inst=%h, required 1/0000/%h",
               o_valid, o_process_counter, o_instruction, word_of(16'h0000));
    end
  endtask

  // Reset asserted with data buffered and requests in flight.
  task automatic test_reset_midstream();
    do_reset();
    mem_latency = 3;
    for (int c = 0; c < 5; c++) tick();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL rm_pre: valid=%b pc=%h, required 1/0000", o_valid, o_process_counter);
    end
    rst = 1'b1;
    clear_mem();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_instruction !== 32'h0 || o_process_counter !== 16'h0 ||
        o_mem_req !== 1'b0 || o_mem_addr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL rm_async: valid=%b inst=%h pc=%h req=%b addr=%h, required all 0",
               o_valid, o_instruction, o_process_counter, o_mem_req, o_mem_addr);
    end
    tick();
    tick();
    rst         = 1'b0;
    mem_latency = 1;
    i_ready     = 1'b1;
    #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000 || o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rm_restart: req=%b addr=%h valid=%b, required 1/0000/0", o_mem_req, o_mem_addr, o_valid);
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rm_no_stale: valid=%b pc=%h, required valid 0", o_valid, o_process_counter);
    end
    tick();
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_process_counter !== 16'h0000 || o_instruction !== word_of(16'h0000)) begin
      errors++;
      $display("[TB] FAIL rm_first: valid=%b pc=%h inst=%h, required 1/0000/%h",
               o_valid, o_process_counter, o_instruction, word_of(16'h0000));
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_discard();
    test_jump_same_cycle();
    test_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
